// File: rtl/pre_if_stage_pkg.sv
// Shared widths, reset vector and PS state encodings for the pre-fetch stage.
package pre_if_stage_pkg;

    localparam int          PS_TO_FS_BUS_WD = 32;
    localparam int          BR_BUS_WD       = 33;
    localparam logic [31:0] RESET_PC        = 32'hbfc00000;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_REQ  = 2'd1,
        PS_WAIT = 2'd2
    } ps_state_e;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ps_redirect_buf.sv
// Holds a pending branch target and a pending flush target; flush outranks branch,
// and a flush arriving this cycle outranks everything already buffered.
module ps_redirect_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        take,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic        br_valid;
    logic [31:0] br_pc;
    logic        flush_valid;
    logic [31:0] flush_tgt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_valid    <= 1'b0;
            br_pc       <= 32'd0;
            flush_valid <= 1'b0;
            flush_tgt   <= 32'd0;
        end else if (flush) begin
            // A flush consumed in the same cycle goes straight into nextpc.
            flush_valid <= ~take;
            flush_tgt   <= flush_pc;
            br_valid    <= 1'b0;
        end else begin
            if (take) begin
                flush_valid <= 1'b0;
                br_valid    <= 1'b0;
            end
            // Branches issued on a path already being flushed are wrong-path.
            if (br_taken && (take || !flush_valid)) begin
                br_valid <= 1'b1;
                br_pc    <= br_target;
            end
        end
    end

    assign redirect_valid = flush | flush_valid | br_valid;
    assign redirect_pc    = flush       ? flush_pc  :
                            flush_valid ? flush_tgt : br_pc;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-fetch stage: owns nextpc, runs the single-outstanding icache request FSM and
// picks sequential / branch / flush successor PCs.
module pre_if_stage
    import pre_if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
    output logic                       inst_req,
    output logic [31:0]                inst_addr,
    input  logic                       inst_addr_ok,
    input  logic                       inst_data_ok,
    output logic [1:0]                 ps_state
);

    // Handshake: inst_req is the valid, inst_addr_ok the ready; the request transfers on the
    // edge where both are high, and inst_req/inst_addr never change while inst_req waits.
    ps_state_e   state, state_d;
    logic [31:0] nextpc, nextpc_d;
    logic        done, done_d;
    logic        cancel, cancel_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        data_present, absorb, fire_fetch, fire_mis, idle_flush, take;

    ps_redirect_buf u_redirect_buf (
        .clk            (clk),
        .reset          (reset),
        .br_taken       (br_bus[32]),
        .br_target      (br_bus[31:0]),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .take           (take),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // done marks data already returned but held because IF was not ready.
    assign data_present = (state == PS_WAIT) && (inst_data_ok || done);
    assign absorb       = data_present && (cancel || flush);
    assign fire_fetch   = data_present && !cancel && !flush && fs_allowin;
    assign idle_flush   = (state == PS_IDLE) && flush;
    assign fire_mis     = (state == PS_IDLE) && pc_misaligned(nextpc) && fs_allowin && !flush;
    assign take         = absorb || fire_fetch || fire_mis || idle_flush;

    always_comb begin
        state_d  = state;
        done_d   = done;
        cancel_d = cancel;
        case (state)
            PS_IDLE: if (!flush && !pc_misaligned(nextpc)) state_d = PS_REQ;
            PS_REQ:  if (inst_addr_ok) state_d = PS_WAIT;
            PS_WAIT: begin
                if (absorb || fire_fetch) begin
                    state_d = PS_IDLE;
                    done_d  = 1'b0;
                end else if (inst_data_ok) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = PS_IDLE;
        endcase
        if (absorb)
            cancel_d = 1'b0;
        else if (flush && state != PS_IDLE)
            cancel_d = 1'b1;
        nextpc_d = nextpc;
        if (take)
            nextpc_d = redirect_valid ? redirect_pc : nextpc + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PS_IDLE;
            nextpc <= RESET_PC;
            done   <= 1'b0;
            cancel <= 1'b0;
        end else begin
            state  <= state_d;
            nextpc <= nextpc_d;
            done   <= done_d;
            cancel <= cancel_d;
        end
    end

    assign inst_req     = (state == PS_REQ);
    assign inst_addr    = nextpc;
    assign ps_to_fs_bus = nextpc;
    assign ps_state     = state;

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: vector table plus hand sequences for reset,
// flush/data collision and PC wrap; accepted fetch addresses go through a scoreboard.
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic [32:0] br_bus;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] ps_to_fs_bus;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [1:0]  ps_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2;

    typedef struct {
        logic        allow;
        logic        aok;
        logic        dok;
        logic        brt;
        logic [31:0] brtgt;
        logic        fl;
        logic [31:0] flpc;
        logic [1:0]  st;
        logic        rq;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[31];

    pre_if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .fs_allowin   (fs_allowin),
        .br_bus       (br_bus),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .ps_to_fs_bus (ps_to_fs_bus),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .ps_state     (ps_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic allow, input logic aok, input logic dok,
                                input logic brt, input logic [31:0] brtgt,
                                input logic fl, input logic [31:0] flpc,
                                input logic [1:0] st, input logic rq, input logic [31:0] pc);
        vec_t v;
        v.allow = allow; v.aok = aok; v.dok = dok; v.brt = brt; v.brtgt = brtgt;
        v.fl = fl; v.flpc = flpc; v.st = st; v.rq = rq; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [1:0] st, input logic rq,
                               input logic [31:0] pc);
        chk({tag, " state"}, {30'd0, ps_state}, {30'd0, st});
        chk({tag, " inst_req"}, {31'd0, inst_req}, {31'd0, rq});
        chk({tag, " inst_addr"}, inst_addr, pc);
        chk({tag, " ps_to_fs_bus"}, ps_to_fs_bus, pc);
    endtask

    // driver: inputs set just after an edge, outputs checked just after the next edge
    task automatic run_vec(input string tag, input vec_t v);
        fs_allowin   = v.allow;
        inst_addr_ok = v.aok;
        inst_data_ok = v.dok;
        br_bus       = {v.brt, v.brtgt};
        flush        = v.fl;
        flush_pc     = v.flpc;
        @(posedge clk);
        #1;
        chk_outputs(tag, v.st, v.rq, v.pc);
    endtask

    // scoreboard of addresses accepted by the cache
    always @(negedge clk) begin
        if (!reset && inst_req && inst_addr_ok) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_addr: got %h expected none", inst_addr);
            end else begin
                if (inst_addr !== exp_q[0]) begin
                    errors++;
                    $display("FAIL accept_addr: got %h expected %h", inst_addr, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00000);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00000);
        vecs[2]  = mk(1, 0, 1, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00004);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00004);
        vecs[4]  = mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00004);
        vecs[5]  = mk(1, 0, 1, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00008);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00008);
        // branch raised while bfc00008 is in flight (delay slot)
        vecs[7]  = mk(1, 1, 0, 1, 32'hbfc00100, 0, 0, S_WAIT, 0, 32'hbfc00008);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00008);
        vecs[9]  = mk(1, 0, 1, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00100);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00100);
        // backpressure: data returns while IF stalls for three cycles
        vecs[11] = mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00100);
        vecs[12] = mk(0, 0, 1, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00100);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00100);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00100);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00104);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00104);
        // flush while REQ is pending: request held, data absorbed
        vecs[17] = mk(1, 0, 0, 0, 0, 1, 32'hbfc00380, S_REQ, 1, 32'hbfc00104);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00104);
        vecs[19] = mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00104);
        vecs[20] = mk(1, 0, 1, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00380);
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00380);
        vecs[22] = mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00380);
        vecs[23] = mk(1, 0, 1, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00384);
        // misaligned redirect: no request, advances only with fs_allowin
        vecs[24] = mk(1, 0, 0, 0, 0, 1, 32'hbfc00382, S_IDLE, 0, 32'hbfc00382);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00382);
        vecs[26] = mk(1, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00386);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00386);
        vecs[28] = mk(0, 0, 0, 0, 0, 1, 32'hbfc00400, S_IDLE, 0, 32'hbfc00400);
        vecs[29] = mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00400);
        vecs[30] = mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00400);

        exp_q = {32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc00100, 32'hbfc00104,
                 32'hbfc00380, 32'hbfc00400, 32'hbfc00000, 32'hbfc00500, 32'hfffffffc};

        reset        = 1'b1;
        fs_allowin   = 1'b0;
        br_bus       = 33'd0;
        flush        = 1'b0;
        flush_pc     = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset", S_IDLE, 1'b0, 32'hbfc00000);
        reset = 1'b0;

        for (int i = 0; i < 31; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // reset asserted mid-WAIT takes effect without a clock edge
        reset = 1'b1;
        #1;
        chk_outputs("reset_mid_wait", S_IDLE, 1'b0, 32'hbfc00000);
        @(negedge clk);
        reset = 1'b0;
        run_vec("post_reset", mk(1, 0, 0, 0, 0, 0, 0, S_REQ, 1, 32'hbfc00000));

        // flush, branch and data_ok together: data cancelled, branch dropped
        run_vec("coll_aok",  mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00000));
        run_vec("coll_hit",  mk(1, 0, 1, 1, 32'hbfc00600, 1, 32'hbfc00500, S_IDLE, 0, 32'hbfc00500));
        run_vec("coll_req",  mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hbfc00500));
        run_vec("coll_wait", mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hbfc00500));
        run_vec("coll_seq",  mk(1, 0, 1, 0, 0, 0, 0, S_IDLE, 0, 32'hbfc00504));

        // sequential increment wraps at the top of the address space
        run_vec("wrap_fl",   mk(1, 0, 0, 0, 0, 1, 32'hfffffffc, S_IDLE, 0, 32'hfffffffc));
        run_vec("wrap_req",  mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'hfffffffc));
        run_vec("wrap_wait", mk(1, 1, 0, 0, 0, 0, 0, S_WAIT, 0, 32'hfffffffc));
        run_vec("wrap_next", mk(1, 0, 1, 0, 0, 0, 0, S_IDLE, 0, 32'h00000000));
        run_vec("wrap_req2", mk(1, 0, 0, 0, 0, 0, 0, S_REQ,  1, 32'h00000000));

        @(negedge clk);
        chk("scoreboard_left", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
